// File: rtl/asicle_pkg.sv
// asicle_pkg: shared geometry, tile styles and state encodings for the board writer
package asicle_pkg;

    localparam int ROWS     = 6;
    localparam int COLS     = 5;
    localparam int TILE_W   = 8;
    localparam int STATUS_W = ROWS * COLS * TILE_W;

    localparam logic [2:0] STYLE_EMPTY   = 3'd0;
    localparam logic [2:0] STYLE_TYPED   = 3'd1;
    localparam logic [2:0] STYLE_ABSENT  = 3'd2;
    localparam logic [2:0] STYLE_PRESENT = 3'd3;
    localparam logic [2:0] STYLE_CORRECT = 3'd4;

    localparam logic [4:0] LETTER_BLANK = 5'h1f;
    localparam logic [7:0] TILE_EMPTY   = {STYLE_EMPTY, LETTER_BLANK};

    typedef enum logic [1:0] {EV_IDLE, EV_GREEN, EV_YEL} eval_state_t;
    typedef enum logic {BW_IDLE, BW_EVAL} bw_state_t;

    // Bit offset of tile (r,c) inside the flat status vector
    function automatic int tile_idx(input logic [2:0] r, input logic [2:0] c);
        return 32'(r) * COLS * TILE_W + 32'(c) * TILE_W;
    endfunction

endpackage

// File: rtl/board_writer_guess_eval.sv
// guess_eval: scores a five-letter guess against the target, one pass per cycle
module guess_eval
    import asicle_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        start,
    input  logic [24:0] guess,
    input  logic [24:0] target,
    output logic        done,
    output logic [4:0]  g,
    output logic [4:0]  p
);

    eval_state_t r_state;
    logic [2:0]  r_idx;
    logic [24:0] r_guess;
    logic [24:0] r_target;
    logic [4:0]  r_used;
    logic [4:0]  r_g;
    logic [4:0]  r_p;
    logic        r_done;
    logic [4:0]  w_green;
    logic [4:0]  w_cur;
    logic        w_found;
    logic [2:0]  w_j;

    // Exact matches and the lowest still-unused target slot holding the current guess letter
    always_comb begin
        w_green = '0;
        w_cur   = r_guess[r_idx*5 +: 5];
        w_found = 1'b0;
        w_j     = 3'd0;
        for (int i = 0; i < COLS; i++)
            w_green[i] = r_guess[i*5 +: 5] == r_target[i*5 +: 5];
        for (int j = COLS - 1; j >= 0; j--)
            if (!r_used[j] && r_target[j*5 +: 5] == w_cur) begin
                w_found = 1'b1;
                w_j     = 3'(j);
            end
    end

    // Scoring sequencer: GREEN pass, then one yellow pass per guess column
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= EV_IDLE;
            r_idx    <= '0;
            r_guess  <= '0;
            r_target <= '0;
            r_used   <= '0;
            r_g      <= '0;
            r_p      <= '0;
            r_done   <= 1'b0;
        end else if (clr) begin
            r_state <= EV_IDLE;
            r_idx   <= '0;
            r_used  <= '0;
            r_g     <= '0;
            r_p     <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                EV_IDLE: if (start) begin
                    r_guess  <= guess;
                    r_target <= target;
                    r_p      <= '0;
                    r_state  <= EV_GREEN;
                end
                EV_GREEN: begin
                    r_g     <= w_green;
                    r_used  <= w_green;
                    r_idx   <= '0;
                    r_state <= EV_YEL;
                end
                default: begin
                    if (!r_g[r_idx] && w_found) begin
                        r_p[r_idx]  <= 1'b1;
                        r_used[w_j] <= 1'b1;
                    end
                    if (r_idx == 3'd4) begin
                        r_done  <= 1'b1;
                        r_state <= EV_IDLE;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
            endcase
        end
    end

    assign done = r_done;
    assign g    = r_g;
    assign p    = r_p;

endmodule

// File: rtl/board_writer.sv
// board_writer: builds guess rows from key events and writes scored tile styles
module board_writer
    import asicle_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           key_valid,
    input  logic [4:0]     key_letter,
    input  logic           key_bksp,
    input  logic           key_enter,
    input  logic           new_game,
    input  logic [24:0]    target,
    output logic [239:0]   status,
    output logic [2:0]     row,
    output logic [2:0]     col,
    output logic           busy,
    output logic           game_won,
    output logic           game_lost
);

    bw_state_t     r_state;
    logic [239:0]  r_status;
    logic [2:0]    r_row;
    logic [2:0]    r_col;
    logic          r_busy;
    logic          r_won;
    logic          r_lost;
    logic [24:0]   r_target;
    logic [24:0]   w_guess;
    logic          w_key;
    logic          w_enter;
    logic          w_bksp;
    logic          w_letter;
    logic          w_done;
    logic [4:0]    w_g;
    logic [4:0]    w_p;

    // Current row letters and key decode: enter beats backspace beats letter
    always_comb begin
        w_guess = '0;
        for (int c = 0; c < COLS; c++)
            w_guess[c*5 +: 5] = r_status[tile_idx(r_row, 3'(c)) +: 5];
        w_key    = key_valid && r_state == BW_IDLE && !r_won && !r_lost;
        w_enter  = w_key && key_enter && r_col == 3'd5;
        w_bksp   = w_key && !key_enter && key_bksp && r_col != 3'd0;
        w_letter = w_key && !key_enter && !key_bksp && r_col < 3'd5 && key_letter <= 5'd25;
    end

    guess_eval u_eval (
        .clk    (clk),
        .rst    (rst),
        .clr    (new_game),
        .start  (w_enter && !new_game),
        .guess  (w_guess),
        .target (r_target),
        .done   (w_done),
        .g      (w_g),
        .p      (w_p)
    );

    // Board FSM: edits the active row while idle, writes styles and flags when scoring ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= BW_IDLE;
            r_status <= {(ROWS*COLS){TILE_EMPTY}};
            r_row    <= '0;
            r_col    <= '0;
            r_busy   <= 1'b0;
            r_won    <= 1'b0;
            r_lost   <= 1'b0;
            r_target <= '0;
        end else if (new_game) begin
            r_state  <= BW_IDLE;
            r_status <= {(ROWS*COLS){TILE_EMPTY}};
            r_row    <= '0;
            r_col    <= '0;
            r_busy   <= 1'b0;
            r_won    <= 1'b0;
            r_lost   <= 1'b0;
            r_target <= target;
        end else begin
            case (r_state)
                BW_IDLE: begin
                    if (w_enter) begin
                        r_state <= BW_EVAL;
                        r_busy  <= 1'b1;
                    end else if (w_bksp) begin
                        r_col <= r_col - 3'd1;
                        r_status[tile_idx(r_row, r_col - 3'd1) +: 8] <= TILE_EMPTY;
                    end else if (w_letter) begin
                        r_col <= r_col + 3'd1;
                        r_status[tile_idx(r_row, r_col) +: 8] <= {STYLE_TYPED, key_letter};
                    end
                end
                default: if (w_done) begin
                    for (int c = 0; c < COLS; c++)
                        r_status[tile_idx(r_row, 3'(c)) + 5 +: 3] <= w_g[c] ? STYLE_CORRECT :
                                                                     w_p[c] ? STYLE_PRESENT : STYLE_ABSENT;
                    if (&w_g)
                        r_won <= 1'b1;
                    else if (r_row == 3'(ROWS - 1))
                        r_lost <= 1'b1;
                    else
                        r_row <= r_row + 3'd1;
                    r_col   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= BW_IDLE;
                end
            endcase
        end
    end

    assign status    = r_status;
    assign row       = r_row;
    assign col       = r_col;
    assign busy      = r_busy;
    assign game_won  = r_won;
    assign game_lost = r_lost;

endmodule

// File: tb/tb_board_writer.sv
// tb_board_writer: scoreboard bench driving key events against a transaction-level board model
module tb_board_writer;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic [4:0]   key_letter;
    logic         key_bksp;
    logic         key_enter;
    logic         new_game;
    logic [24:0]  target;
    logic [239:0] status;
    logic [2:0]   row;
    logic [2:0]   col;
    logic         busy;
    logic         game_won;
    logic         game_lost;

    board_writer dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_letter (key_letter),
        .key_bksp   (key_bksp),
        .key_enter  (key_enter),
        .new_game   (new_game),
        .target     (target),
        .status     (status),
        .row        (row),
        .col        (col),
        .busy       (busy),
        .game_won   (game_won),
        .game_lost  (game_lost)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [239:0] st;
        logic [2:0]   row;
        logic [2:0]   col;
        logic         busy;
        logic         won;
        logic         lost;
    } exp_t;

    exp_t         q[$];
    int           n_chk = 0;
    int           n_err = 0;
    logic [239:0] m_st;
    int           m_row;
    int           m_col;
    logic         m_busy;
    logic         m_won;
    logic         m_lost;
    logic [24:0]  m_tgt;

    localparam logic [24:0] W_ABBEY = {5'd24, 5'd4, 5'd1, 5'd1, 5'd0};
    localparam logic [24:0] W_BABBY = {5'd24, 5'd1, 5'd1, 5'd0, 5'd1};
    localparam logic [24:0] W_QQQQQ = {5{5'd16}};
    localparam logic [24:0] W_ZZZZZ = {5{5'd25}};
    localparam logic [24:0] W_CRANE = {5'd4, 5'd13, 5'd0, 5'd17, 5'd2};
    localparam logic [24:0] W_HELLO = {5'd14, 5'd11, 5'd11, 5'd4, 5'd7};
    localparam logic [24:0] W_AAAAA = '0;

    task automatic check(input string tag, input logic [239:0] act, input logic [239:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_clear(input logic [24:0] t);
        m_st   = {30{8'h1f}};
        m_row  = 0;
        m_col  = 0;
        m_busy = 1'b0;
        m_won  = 1'b0;
        m_lost = 1'b0;
        m_tgt  = t;
    endtask

    task automatic push_exp();
        q.push_back({m_st, 3'(m_row), 3'(m_col), m_busy, m_won, m_lost});
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            check({tag, "/queue_empty"}, 240'd0, 240'd1);
            return;
        end
        e = q.pop_front();
        check({tag, "/status"}, status, e.st);
        check({tag, "/row"}, 240'(row), 240'(e.row));
        check({tag, "/col"}, 240'(col), 240'(e.col));
        check({tag, "/busy"}, 240'(busy), 240'(e.busy));
        check({tag, "/won"}, 240'(game_won), 240'(e.won));
        check({tag, "/lost"}, 240'(game_lost), 240'(e.lost));
    endtask

    // Reference scoring: exact matches first, then present letters from leftover target counts
    task automatic model_score();
        int          cnt[32];
        logic [4:0]  gl[5];
        logic [4:0]  tl[5];
        logic [4:0]  gm;
        logic [2:0]  sty;
        for (int k = 0; k < 32; k++) cnt[k] = 0;
        for (int i = 0; i < 5; i++) begin
            gl[i] = m_st[m_row*40 + i*8 +: 5];
            tl[i] = m_tgt[i*5 +: 5];
            gm[i] = gl[i] == tl[i];
            if (!gm[i]) cnt[tl[i]]++;
        end
        for (int i = 0; i < 5; i++) begin
            if (gm[i]) sty = 3'd4;
            else if (cnt[gl[i]] > 0) begin
                sty = 3'd3;
                cnt[gl[i]]--;
            end else sty = 3'd2;
            m_st[m_row*40 + i*8 + 5 +: 3] = sty;
        end
        if (&gm) m_won = 1'b1;
        else if (m_row == 5) m_lost = 1'b1;
        else m_row++;
        m_col  = 0;
        m_busy = 1'b0;
    endtask

    task automatic run_score(input bit drop);
        for (int i = 0; i < 7; i++) begin
            if (drop && i == 1) begin
                key_valid  = 1'b1;
                key_letter = 5'd3;
            end
            if (i == 2) key_valid = 1'b0;
            @(negedge clk);
            if (i == 6) model_score();
            push_exp();
            check_out($sformatf("score%0d", i));
        end
    endtask

    task automatic key(input bit bk, input bit en, input logic [4:0] l, input bit drop);
        bit go = 0;
        @(negedge clk);
        key_valid  = 1'b1;
        key_bksp   = bk;
        key_enter  = en;
        key_letter = l;
        @(negedge clk);
        key_valid = 1'b0;
        key_bksp  = 1'b0;
        key_enter = 1'b0;
        if (!m_won && !m_lost) begin
            if (en) go = m_col == 5;
            else if (bk) begin
                if (m_col > 0) begin
                    m_col--;
                    m_st[m_row*40 + m_col*8 +: 8] = 8'h1f;
                end
            end else if (m_col < 5 && l <= 5'd25) begin
                m_st[m_row*40 + m_col*8 +: 8] = {3'd1, l};
                m_col++;
            end
        end
        m_busy = go;
        push_exp();
        check_out(en ? "enter" : bk ? "bksp" : "letter");
        if (go) run_score(drop);
    endtask

    task automatic type_word(input logic [24:0] w);
        for (int i = 0; i < 5; i++) key(1'b0, 1'b0, w[i*5 +: 5], 1'b0);
    endtask

    task automatic start_game(input logic [24:0] t);
        @(negedge clk);
        new_game = 1'b1;
        target   = t;
        @(negedge clk);
        new_game = 1'b0;
        model_clear(t);
        push_exp();
        check_out("new_game");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        key_valid  = 1'b0;
        key_letter = '0;
        key_bksp   = 1'b0;
        key_enter  = 1'b0;
        new_game   = 1'b0;
        target     = '0;
        model_clear('0);
        repeat (2) @(negedge clk);
        push_exp();
        check_out("reset");
        rst = 1'b0;

        for (int i = 0; i < 3; i++) key(1'b0, 1'b0, 5'(i), 1'b0);
        check("abc_tiles", 240'(status[39:0]), 240'(40'h1f_1f_22_21_20));
        key(1'b0, 1'b0, 5'd27, 1'b0);
        for (int i = 0; i < 3; i++) key(1'b1, 1'b0, 5'd0, 1'b0);

        for (int i = 0; i < 6; i++) key(1'b0, 1'b0, 5'(10 + i), 1'b0);
        check("six_letters_col", 240'(col), 240'd5);
        for (int i = 0; i < 7; i++) key(1'b1, 1'b0, 5'd0, 1'b0);
        check("bksp_row_empty", 240'(status[39:0]), 240'({5{8'h1f}}));
        key(1'b0, 1'b1, 5'd0, 1'b0);

        start_game(W_ABBEY);
        type_word(W_BABBY);
        key(1'b0, 1'b1, 5'd0, 1'b1);
        check("abbey_styles", 240'(status[39:0]), 240'(40'h98_41_81_60_61));

        type_word(W_QQQQQ);
        key(1'b0, 1'b1, 5'd0, 1'b0);
        type_word(W_ABBEY);
        key(1'b0, 1'b1, 5'd0, 1'b0);
        check("won_flag", 240'(game_won), 240'd1);
        key(1'b0, 1'b0, 5'd5, 1'b0);
        key(1'b1, 1'b0, 5'd0, 1'b0);

        start_game(W_CRANE);
        for (int r = 0; r < 6; r++) begin
            type_word(W_ZZZZZ);
            key(1'b0, 1'b1, 5'd0, 1'b0);
        end
        check("lost_flag", 240'(game_lost), 240'd1);
        key(1'b0, 1'b0, 5'd1, 1'b0);
        start_game(W_HELLO);

        type_word(W_ZZZZZ);
        @(negedge clk);
        key_valid = 1'b1;
        key_enter = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        key_enter = 1'b0;
        m_busy = 1'b1;
        push_exp();
        check_out("abort_enter");
        repeat (3) @(negedge clk);
        new_game = 1'b1;
        target   = W_CRANE;
        @(negedge clk);
        new_game = 1'b0;
        model_clear(W_CRANE);
        push_exp();
        check_out("abort");
        repeat (8) @(negedge clk);
        push_exp();
        check_out("abort_quiet");
        type_word(W_CRANE);
        key(1'b0, 1'b1, 5'd0, 1'b0);
        check("abort_new_target_won", 240'(game_won), 240'd1);

        start_game(W_HELLO);
        key(1'b0, 1'b0, 5'd7, 1'b0);
        key(1'b0, 1'b0, 5'd4, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        model_clear('0);
        push_exp();
        check_out("async_rst");
        @(negedge clk);
        rst = 1'b0;
        type_word(W_AAAAA);
        key(1'b0, 1'b1, 5'd0, 1'b0);
        check("rst_target_zero_won", 240'(game_won), 240'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
